instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
- Decode stage between instruction fetch and the control unit / register-file read.
- Accepts a fetched 32-bit instruction plus its PC over a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Splits the instruction into opcode, I bit, modifier, register addresses and immediate.
- Computes the expanded immediate and the branch target, and presents registered fields to the control unit.

Parameters:
- PC_W, 32, width of program counter and branch target.
- RA_REG, 15, register index used as return-address source for ret.
- NOP_OPCODE, 5'b01101, opcode substituted on flush/illegal.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- flush  in  1  branch taken downstream; discard all buffered instructions.
- inValid  in  1  fetch presents instruction.
- inReady  out  1  stage can accept.
- inInst  in  32  instruction word.
- inPc  in  PC_W  PC of inInst.
- outValid  out  1  head entry valid.
- outReady  in  1  control unit consumes head.
- opcode  out  5  inst[31:27].
- iOrReg  out  1  inst[26].
- modifier  out  2  inst[17:16].
- rd  out  4  inst[25:22].
- rs1  out  4  inst[21:18]; forced to RA_REG when opcode=5'b10100 (ret).
- rs2  out  4  inst[17:14]; forced to rd when opcode=5'b01111 (st).
- immx  out  32  expanded immediate.
- brTarget  out  PC_W  branch target.
- pcOut  out  PC_W  PC of head.
- illegal  out  1  see Optional Feature.

Behaviour:
- Reset (rstN=0, async): state=EMPTY; outValid=0; inReady=1; opcode=NOP_OPCODE; all other outputs 0.
- Handshakes:
  - Push when inValid & inReady.
  - Pop when outValid & outReady.
  - Upstream must hold inInst/inPc stable while inValid=1 and inReady=0.
- inReady is registered: 1 in EMPTY and ONE, 0 in TWO. It never depends combinationally on outReady.
- States and transitions:
  - EMPTY: push -> ONE (head <= input).
  - ONE, push only: -> TWO (skid <= input).
  - ONE, pop only: -> EMPTY.
  - ONE, push and pop: stay ONE (head <= input).
  - TWO, pop: -> ONE (head <= skid). No push possible in TWO.
  - Otherwise: hold.
- Latency: an instruction pushed at edge N is on the outputs with outValid=1 after edge N (1 cycle). Fields never change while outValid=1 and outReady=0.
- Decode is performed at write into head or skid. Outputs come straight from head registers; there is no combinational path from inInst to outputs.
- immx from inst[15:0] by modifier:
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: imm16 << 16.
  - 11: treated as 00.
- brTarget = pc + (signext(inst[26:0]) << 2), modulo 2^PC_W (wrap-around ignored, no overflow flag). Computed for every opcode; the consumer uses it only for 10000..10011.
- flush (synchronous, highest priority):
  - Next state EMPTY, outValid=0, opcode=NOP_OPCODE.
  - Any push or pop in the same cycle is discarded.
  - inReady=1 after the flush edge.
- Reset asserted mid-transfer: all entries dropped immediately, no partial output.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 5'd21..5'd31 set illegal=1 on that entry.
  - The entry's opcode is replaced by NOP_OPCODE; rd/rs1/rs2/immx are zeroed.
  - illegal is held with the entry and popped normally.
- Not defined:
  - illegal is constant 0.
  - All opcodes pass through unchanged.

Test Plan:
- Reset then single push:
  - Stimulus: inInst=0x0048_FFFF (add, rd=1, rs1=2, I=0), inPc=0x100, outReady=1.
  - Response: after 1 edge outValid=1, opcode=0, rd=1, rs1=2, immx=0xFFFF_FFFF, pcOut=0x100.
  - Next edge: outValid=0.
- Modifier expansion with imm16=0x8001:
  - mod 00 -> immx=0xFFFF_8001.
  - mod 01 -> immx=0x0000_8001.
  - mod 10 -> immx=0x8001_0000.
- Backpressure:
  - Stimulus: outReady=0, push 3 back-to-back instructions A, B, C.
  - Response: A and B accepted; inReady=0 after the 2nd push; C is held.
  - Then raise outReady: order A, B, C is preserved and no instruction is duplicated.
- Branch and special registers:
  - beq (0x8000_0003) at pc=0x200 -> brTarget=0x20C.
  - Offset 0x7FF_FFFF (−1) at pc=0x200 -> brTarget=0x1FC.
  - ret -> rs1=15.
  - st with rd=5 -> rs2=5.
- Flush in TWO state:
  - Stimulus: flush=1 together with outReady=1 and inValid=1.
  - Response: next cycle outValid=0, inReady=1, opcode=5'b01101; the input offered in the flush cycle is discarded.
- Illegal opcode (with DECODE_ILLEGAL_TRAP_EN):
  - opcode 5'd25 -> illegal=1, opcode=5'b01101.
  - Without the macro: illegal=0, opcode=25.

Source files
------------

// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and control-unit-side signals of the decode stage.
// slave is the decode stage's view; master is the fetch/control-unit view.
interface instruction_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            inValid;
  logic            inReady;
  logic [31:0]     inInst;
  logic [PC_W-1:0] inPc;
  logic            outValid;
  logic            outReady;
  logic [4:0]      opcode;
  logic            iOrReg;
  logic [1:0]      modifier;
  logic [3:0]      rd;
  logic [3:0]      rs1;
  logic [3:0]      rs2;
  logic [31:0]     immx;
  logic [PC_W-1:0] brTarget;
  logic [PC_W-1:0] pcOut;
  logic            illegal;

  modport slave (
    input  inValid, inInst, inPc, outReady,
    output inReady, outValid, opcode, iOrReg, modifier, rd, rs1, rs2,
           immx, brTarget, pcOut, illegal
  );

  modport master (
    output inValid, inInst, inPc, outReady,
    input  inReady, outValid, opcode, iOrReg, modifier, rd, rs1, rs2,
           immx, brTarget, pcOut, illegal
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// Decode stage: 2-entry skid buffer holding pre-decoded instructions.
// Optional macro DECODE_ILLEGAL_TRAP_EN turns opcodes 21..31 into flagged NOPs.
module instruction_decode_stage #(
  parameter int         PC_W       = 32,
  parameter int         RA_REG     = 15,
  parameter logic [4:0] NOP_OPCODE = 5'b01101
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 flush,
  instruction_decode_stage_if.slave bus
);

  typedef struct packed {
    logic            illegal;
    logic [4:0]      opcode;
    logic            iOrReg;
    logic [1:0]      modifier;
    logic [3:0]      rd;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [31:0]     immx;
    logic [PC_W-1:0] brTarget;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic entry_t decode(input logic [31:0] inst, input logic [PC_W-1:0] pc);
    entry_t          e;
    logic [PC_W-1:0] off;
    e          = '0;
    e.opcode   = inst[31:27];
    e.iOrReg   = inst[26];
    e.modifier = inst[17:16];
    e.rd       = inst[25:22];
    e.rs1      = (inst[31:27] == 5'b10100) ? 4'(RA_REG) : inst[21:18];
    e.rs2      = (inst[31:27] == 5'b01111) ? inst[25:22] : inst[17:14];
    case (inst[17:16])
      2'b01:   e.immx = {16'h0000, inst[15:0]};
      2'b10:   e.immx = {inst[15:0], 16'h0000};
      default: e.immx = {{16{inst[15]}}, inst[15:0]};
    endcase
    // Word offset: sign-extend the 27-bit field, then scale by 4.
    off        = {{(PC_W-27){inst[26]}}, inst[26:0]};
    e.brTarget = pc + {off[PC_W-3:0], 2'b00};
    e.pc       = pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (inst[31:27] >= 5'd21) begin
      e.illegal = 1'b1;
      e.opcode  = NOP_OPCODE;
      e.rd      = '0;
      e.rs1     = '0;
      e.rs2     = '0;
      e.immx    = '0;
    end
`endif
    return e;
  endfunction

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t dec_in;
  logic   out_valid;
  logic   in_ready;
  logic   push;
  logic   pop;

  always_comb begin
    dec_in = decode(bus.inInst, bus.inPc);
    push   = bus.inValid & in_ready;
    pop    = out_valid & bus.outReady;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      head        <= '0;
      head.opcode <= NOP_OPCODE;
      skid        <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      head.opcode <= NOP_OPCODE;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= dec_in;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= dec_in;
          end else if (push) begin
            skid     <= dec_in;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head     <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.opcode   = head.opcode;
  assign bus.iOrReg   = head.iOrReg;
  assign bus.modifier = head.modifier;
  assign bus.rd       = head.rd;
  assign bus.rs1      = head.rs1;
  assign bus.rs2      = head.rs2;
  assign bus.immx     = head.immx;
  assign bus.brTarget = head.brTarget;
  assign bus.pcOut    = head.pc;
  assign bus.illegal  = head.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed cases plus a
// randomized run against a queue-based reference model.
module tb_instruction_decode_stage;
  localparam int         PC_W = 32;
  localparam logic [4:0] NOP  = 5'b01101;

  logic clk   = 1'b0;
  logic rstN  = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  instruction_decode_stage_if #(.PC_W(PC_W)) bus ();

  instruction_decode_stage #(.PC_W(PC_W), .RA_REG(15), .NOP_OPCODE(NOP)) dut (
    .clk  (clk),
    .rstN (rstN),
    .flush(flush),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;
  txn_t q[$];

  // Reference decode written directly from the field rules with arithmetic.
  function automatic bit m_illegal(input logic [31:0] inst);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return (inst >> 27) >= 21;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4:0] m_opcode(input logic [31:0] inst);
    return m_illegal(inst) ? NOP : 5'(inst >> 27);
  endfunction

  function automatic logic [3:0] m_rd(input logic [31:0] inst);
    return m_illegal(inst) ? 4'd0 : 4'((inst >> 22) & 15);
  endfunction

  function automatic logic [3:0] m_rs1(input logic [31:0] inst);
    if (m_illegal(inst)) return 4'd0;
    if ((inst >> 27) == 20) return 4'd15;
    return 4'((inst >> 18) & 15);
  endfunction

  function automatic logic [3:0] m_rs2(input logic [31:0] inst);
    if (m_illegal(inst)) return 4'd0;
    if ((inst >> 27) == 15) return 4'((inst >> 22) & 15);
    return 4'((inst >> 14) & 15);
  endfunction

  function automatic logic [31:0] m_immx(input logic [31:0] inst);
    int unsigned imm;
    int unsigned md;
    if (m_illegal(inst)) return 32'd0;
    imm = inst & 32'hFFFF;
    md  = (inst >> 16) & 3;
    if (md == 1) return imm;
    if (md == 2) return imm * 65536;
    return (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
  endfunction

  function automatic logic [31:0] m_br(input logic [31:0] inst, input logic [31:0] pc);
    longint off;
    off = longint'(inst & 32'h07FF_FFFF);
    if (off >= (longint'(1) << 26)) off = off - (longint'(1) << 27);
    return 32'(longint'(pc) + off * 4);
  endfunction

  // Advance one clock and mirror the buffer occupancy in the model queue.
  task automatic step();
    bit push, pop;
    push = bus.inValid && (q.size() < 2);
    pop  = (q.size() > 0) && bus.outReady;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{bus.inInst, bus.inPc});
    end
  endtask

  task automatic clear_buffer();
    bus.inValid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    bus.inInst  = inst;
    bus.inPc    = pc;
    bus.inValid = 1'b1;
    step();
    bus.inValid = 1'b0;
  endtask

  task automatic test_reset();
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.inInst   = 32'h0;
    bus.inPc     = 32'h0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got=%b exp=0", bus.outValid); end
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got=%b exp=1", bus.inReady); end
    checks++; if (bus.opcode !== NOP) begin errors++; $display("FAIL reset_opcode got=%b exp=%b", bus.opcode, NOP); end
    checks++;
    if ({bus.rd, bus.rs1, bus.rs2, bus.immx, bus.brTarget, bus.pcOut, bus.illegal, bus.iOrReg, bus.modifier} !== '0) begin
      errors++; $display("FAIL reset_fields got rd=%h rs1=%h rs2=%h immx=%h br=%h pc=%h exp all zero",
                         bus.rd, bus.rs1, bus.rs2, bus.immx, bus.brTarget, bus.pcOut);
    end
    rstN = 1'b1;
    q.delete();
    step();
  endtask

  task automatic test_reset_mid_transfer();
    clear_buffer();
    bus.outReady = 1'b0;
    push_one(32'h0840_0001, 32'h40);
    push_one(32'h0880_0002, 32'h44);
    #2 rstN = 1'b0;
    #1;
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL midreset_outValid got=%b exp=0", bus.outValid); end
    checks++; if (bus.opcode !== NOP) begin errors++; $display("FAIL midreset_opcode got=%b exp=%b", bus.opcode, NOP); end
    @(negedge clk);
    rstN = 1'b1;
    q.delete();
    step();
    checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      errors++; $display("FAIL midreset_after got outValid=%b inReady=%b exp 0/1", bus.outValid, bus.inReady);
    end
  endtask

  task automatic test_single_push();
    clear_buffer();
    bus.outReady = 1'b1;
    push_one(32'h0048_FFFF, 32'h100);
    checks++; if (bus.outValid !== 1'b1) begin errors++; $display("FAIL single_outValid got=%b exp=1", bus.outValid); end
    checks++;
    if (bus.opcode !== 5'd0 || bus.rd !== 4'd1 || bus.rs1 !== 4'd2) begin
      errors++; $display("FAIL single_fields got op=%0d rd=%0d rs1=%0d exp 0/1/2", bus.opcode, bus.rd, bus.rs1);
    end
    checks++; if (bus.immx !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_immx got=%h exp=ffffffff", bus.immx); end
    checks++; if (bus.pcOut !== 32'h100) begin errors++; $display("FAIL single_pc got=%h exp=100", bus.pcOut); end
    step();
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bus.outValid); end
  endtask

  task automatic test_modifier();
    logic [31:0] exp_tab [4];
    exp_tab = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'hFFFF_8001};
    clear_buffer();
    bus.outReady = 1'b1;
    for (int m = 0; m < 4; m++) begin
      push_one((32'd1 << 27) | (32'(m) << 16) | 32'h8001, 32'h300 + 32'(4 * m));
      checks++;
      if (bus.immx !== exp_tab[m]) begin
        errors++; $display("FAIL modifier_%0d got=%h exp=%h", m, bus.immx, exp_tab[m]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] seen[$];
    bit c_taken;
    clear_buffer();
    bus.outReady = 1'b0;
    push_one(32'h0800_0001, 32'h1000);
    bus.inValid = 1'b1; bus.inInst = 32'h0800_0002; bus.inPc = 32'h1004;
    step();
    checks++; if (bus.inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady_full got=%b exp=0", bus.inReady); end
    bus.inInst = 32'h0800_0003; bus.inPc = 32'h1008;
    step();
    checks++;
    if (bus.inReady !== 1'b0 || bus.outValid !== 1'b1 || bus.pcOut !== 32'h1000 || bus.immx !== 32'h1) begin
      errors++; $display("FAIL bp_hold got inReady=%b outValid=%b pc=%h immx=%h exp 0/1/1000/1",
                         bus.inReady, bus.outValid, bus.pcOut, bus.immx);
    end
    bus.outReady = 1'b1;
    c_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.outValid) seen.push_back(bus.pcOut);
      if (bus.inValid && bus.inReady) c_taken = 1'b1;
      step();
      if (c_taken) bus.inValid = 1'b0;
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'h1000 || seen[1] !== 32'h1004 || seen[2] !== 32'h1008) begin
      errors++; $display("FAIL bp_order got count=%0d first=%h exp 3 entries 1000,1004,1008",
                         seen.size(), (seen.size() > 0) ? seen[0] : 32'h0);
    end
  endtask

  task automatic test_branch_special();
    logic [31:0] insts [4];
    insts = '{32'h8000_0003, 32'h87FF_FFFF, 32'hA00C_0000, 32'h7964_4000};
    clear_buffer();
    bus.outReady = 1'b1;
    push_one(insts[0], 32'h200);
    checks++; if (bus.brTarget !== 32'h20C) begin errors++; $display("FAIL br_fwd got=%h exp=20c", bus.brTarget); end
    push_one(insts[1], 32'h200);
    checks++; if (bus.brTarget !== 32'h1FC) begin errors++; $display("FAIL br_back got=%h exp=1fc", bus.brTarget); end
    push_one(insts[2], 32'h210);
    checks++; if (bus.rs1 !== 4'd15) begin errors++; $display("FAIL ret_rs1 got=%0d exp=15", bus.rs1); end
    push_one(insts[3], 32'h214);
    checks++;
    if (bus.rs2 !== 4'd5 || bus.rd !== 4'd5) begin
      errors++; $display("FAIL st_rs2 got rs2=%0d rd=%0d exp 5/5", bus.rs2, bus.rd);
    end
    step();
  endtask

  task automatic test_flush();
    clear_buffer();
    bus.outReady = 1'b0;
    push_one(32'h0800_0011, 32'h500);
    push_one(32'h0800_0012, 32'h504);
    flush = 1'b1; bus.outReady = 1'b1;
    bus.inValid = 1'b1; bus.inInst = 32'h0800_0013; bus.inPc = 32'h508;
    step();
    flush = 1'b0; bus.inValid = 1'b0;
    checks++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1 || bus.opcode !== NOP) begin
      errors++; $display("FAIL flush_state got outValid=%b inReady=%b op=%b exp 0/1/%b",
                         bus.outValid, bus.inReady, bus.opcode, NOP);
    end
    step();
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL flush_discard got=%b exp=0", bus.outValid); end
  endtask

  task automatic test_illegal();
    clear_buffer();
    bus.outReady = 1'b1;
    push_one((32'd25 << 27) | (32'd3 << 22) | 32'h1234, 32'h600);
`ifdef DECODE_ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal !== 1'b1 || bus.opcode !== NOP || bus.rd !== 4'd0 || bus.immx !== 32'd0) begin
      errors++; $display("FAIL illegal_trap got ill=%b op=%0d rd=%0d immx=%h exp 1/13/0/0",
                         bus.illegal, bus.opcode, bus.rd, bus.immx);
    end
`else
    checks++;
    if (bus.illegal !== 1'b0 || bus.opcode !== 5'd25 || bus.rd !== 4'd3 || bus.immx !== 32'h1234) begin
      errors++; $display("FAIL illegal_pass got ill=%b op=%0d rd=%0d immx=%h exp 0/25/3/1234",
                         bus.illegal, bus.opcode, bus.rd, bus.immx);
    end
`endif
    step();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    clear_buffer();
    for (int i = 0; i < 400; i++) begin
      if (!(bus.inValid && !bus.inReady)) begin
        bus.inValid = ($urandom_range(0, 3) != 0);
        bus.inInst  = $urandom();
        bus.inPc    = $urandom() & 32'hFFFF_FFFC;
      end
      bus.outReady = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      step();
      checks++;
      if (bus.outValid !== (q.size() > 0) || bus.inReady !== (q.size() < 2)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_hs cyc=%0d got outValid=%b inReady=%b exp occupancy=%0d",
                               i, bus.outValid, bus.inReady, q.size());
      end else if (q.size() > 0) begin
        checks++;
        if (bus.opcode !== m_opcode(q[0].inst) || bus.rd !== m_rd(q[0].inst) ||
            bus.rs1 !== m_rs1(q[0].inst) || bus.rs2 !== m_rs2(q[0].inst) ||
            bus.immx !== m_immx(q[0].inst) || bus.brTarget !== m_br(q[0].inst, q[0].pc) ||
            bus.pcOut !== q[0].pc || bus.illegal !== m_illegal(q[0].inst) ||
            bus.iOrReg !== q[0].inst[26] || bus.modifier !== 2'((q[0].inst >> 16) & 3)) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL rand_fields cyc=%0d inst=%h got op=%0d immx=%h br=%h pc=%h exp op=%0d immx=%h br=%h pc=%h",
                                 i, q[0].inst, bus.opcode, bus.immx, bus.brTarget, bus.pcOut,
                                 m_opcode(q[0].inst), m_immx(q[0].inst), m_br(q[0].inst, q[0].pc), q[0].pc);
        end
      end
    end
    flush = 1'b0;
    bus.inValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_modifier();
    test_backpressure();
    test_branch_special();
    test_flush();
    test_illegal();
    test_reset_mid_transfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
